cmem_arbiter: RTL and testbench
===============================

Name: cmem_arbiter

Overview:
Owns the 16 x 4-bit communication memory (cmem) shared between the Amiga clock-port side and the Pi-side access logic. Clock-port strobes are single-cycle and always win. Pi-side accesses use a toggle req/ack handshake and are deferred around clock-port strobes. Also holds the two event/interrupt registers and drives the interrupt lines to both sides.

Parameters:
A2R_ADDR, 4'hC, address of Amiga-to-Pi event register
R2A_ADDR, 4'hE, address of Pi-to-Amiga event register
AEN_ADDR, 4'hF, address of Amiga interrupt-enable register
AEN_RESET, 4'h0, reset value of the interrupt-enable register

Ports:
clk200  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
cp_read_cmem  in  1  one-cycle read strobe from clock port
cp_write_cmem  in  1  one-cycle write strobe from clock port
cp_address  in  4  clock-port address, stable during strobe
cp_data_out  in  4  clock-port write data
cp_in_cmem_out  out  4  clock-port read data (registered)
pi_req  in  1  Pi request toggle; same clock domain
pi_ack  out  1  Pi acknowledge toggle
pi_write  in  1  1 = write, 0 = read; stable while request pending
pi_address  in  4  Pi address; stable while request pending
pi_wdata  in  4  Pi write data; stable while request pending
pi_rdata  out  4  Pi read data (registered)
int_to_pi  out  1  level interrupt to Pi
int_to_amiga  out  1  level interrupt to Amiga

Behaviour:
- Reset (async, reset_n=0): all storage = 0, aen = AEN_RESET, ev_a2r = ev_r2a = 0, cp_in_cmem_out = 0, pi_rdata = 0, pi_ack = 0, state = IDLE. Pi logic shares reset_n, so pi_req also returns to 0.
- Address map, both sides:
  - 0x0–0xB: plain storage, read/write.
  - A2R_ADDR reads ev_a2r. A cp write ORs data into ev_a2r. A Pi write clears the bits written as 1 (W1C).
  - R2A_ADDR reads ev_r2a. A Pi write ORs data in. A cp write clears the bits written as 1 (W1C).
  - AEN_ADDR: cp read/write. A Pi read returns aen; Pi writes are ignored.
  - 0xD: reads 0, writes ignored (see Optional Feature).
- Clock-port access:
  - Serviced in the strobe cycle, regardless of Pi state.
  - Read: cp_in_cmem_out is loaded at the edge ending the strobe cycle, is valid from the next cycle, and is held until the next cp read.
  - Write: takes effect at the same edge.
  - Both strobes high together: write wins, no read update.
- Pi handshake: a request is pending while pi_req != pi_ack.
  - IDLE: if pending, go to PI_ACCESS (detection costs 1 cycle).
  - PI_ACCESS, no cp strobe this cycle: perform the access (write storage/event, or load pi_rdata), toggle pi_ack, go to IDLE. New pi_ack and pi_rdata are visible 2 cycles after the pi_req toggle.
  - PI_ACCESS, cp strobe present: stay in PI_ACCESS and retry next cycle (one-cycle defer).
- Ordering: a cp and a Pi write to the same address in the same cycle → cp applied first, Pi applied one cycle later (final value = Pi data). Set and W1C on an event register never land in the same cycle.
- Pi may toggle pi_req again only after observing the pi_ack toggle. A toggle while one is already pending is not detected separately.
- int_to_amiga = |(ev_r2a & aen), registered (1-cycle lag after the source update).
- int_to_pi = |ev_a2r, registered.
- Undefined state encodings recover to IDLE.

Optional Feature:
Macro CMEM_PI_IRQ_MASK_EN.
- With it: adds a Pi-only register pi_mask (reset 4'hF) at address 0xD.
  - Pi writes load it; Pi reads return it.
  - Clock-port reads of 0xD still return 0, and cp writes there are ignored.
  - int_to_pi = |(ev_a2r & pi_mask).
- Without it: no pi_mask, Pi reads of 0xD return 0, int_to_pi = |ev_a2r.

Test Plan:
- Reset, then cp read of 0x3 and Pi read of AEN_ADDR → cp_in_cmem_out = 0, pi_rdata = AEN_RESET, pi_ack toggles 2 cycles after pi_req.
- cp write 0x5 = 4'hA, then Pi read 0x5 → pi_rdata = 4'hA. Pi write 0x7 = 4'h3, then cp read 0x7 → cp_in_cmem_out = 4'h3 the cycle after the strobe.
- Pi write 0x2 = 4'h6 with a cp write 0x2 = 4'h9 strobe landing in the PI_ACCESS cycle → ack delayed 1 cycle, final cmem[2] = 4'h6, cp_in_cmem_out unchanged.
- cp writes 4'b0101 to 0xC → int_to_pi = 1. Pi writes 4'b0001 to 0xC → ev_a2r = 4'b0100, int_to_pi still 1. Pi writes 4'b0100 → int_to_pi = 0.
- cp writes aen = 4'h2; Pi writes 4'h3 to 0xE → int_to_amiga = 1. cp writes 4'h2 to 0xE → ev_r2a = 4'h1, int_to_amiga = 0.
- With CMEM_PI_IRQ_MASK_EN: Pi writes 0xD = 0, then cp sets ev_a2r = 4'h1 → int_to_pi stays 0; cp read of 0xD returns 0. Assert reset_n mid-request → pi_ack = 0, all registers at reset values.

Source files
------------

// File: rtl/cmem_arbiter.sv
// Shared 16x4 communication memory between the Amiga clock port and the Pi side,
// plus event/interrupt registers. Optional macro CMEM_PI_IRQ_MASK_EN adds a Pi-side irq mask at 0xD.
module cmem_arbiter #(
    parameter logic [3:0] A2R_ADDR  = 4'hC,
    parameter logic [3:0] R2A_ADDR  = 4'hE,
    parameter logic [3:0] AEN_ADDR  = 4'hF,
    parameter logic [3:0] AEN_RESET = 4'h0
) (
    input  logic       clk200,
    input  logic       reset_n,
    input  logic       cp_read_cmem,
    input  logic       cp_write_cmem,
    input  logic [3:0] cp_address,
    input  logic [3:0] cp_data_out,
    output logic [3:0] cp_in_cmem_out,
    input  logic       pi_req,
    output logic       pi_ack,
    input  logic       pi_write,
    input  logic [3:0] pi_address,
    input  logic [3:0] pi_wdata,
    output logic [3:0] pi_rdata,
    output logic       int_to_pi,
    output logic       int_to_amiga
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PI_ACCESS = 2'd1
    } state_t;

    localparam logic [3:0] LAST_PLAIN = 4'hB;

    state_t     state;
    logic [3:0] mem [0:15];
    logic [3:0] ev_a2r;
    logic [3:0] ev_r2a;
    logic [3:0] aen;
    logic [3:0] cp_rd;
    logic [3:0] pi_rd;
    logic       cp_strobe;
    logic       irq_pi_next;

`ifdef CMEM_PI_IRQ_MASK_EN
    localparam logic [3:0] MSK_ADDR = 4'hD;
    logic [3:0] pi_mask;
    assign irq_pi_next = |(ev_a2r & pi_mask);
`else
    assign irq_pi_next = |ev_a2r;
`endif

    assign cp_strobe = cp_read_cmem | cp_write_cmem;

    always_comb begin
        cp_rd = '0;
        if (cp_address <= LAST_PLAIN)     cp_rd = mem[cp_address];
        else if (cp_address == A2R_ADDR)  cp_rd = ev_a2r;
        else if (cp_address == R2A_ADDR)  cp_rd = ev_r2a;
        else if (cp_address == AEN_ADDR)  cp_rd = aen;
    end

    always_comb begin
        pi_rd = '0;
        if (pi_address <= LAST_PLAIN)     pi_rd = mem[pi_address];
        else if (pi_address == A2R_ADDR)  pi_rd = ev_a2r;
        else if (pi_address == R2A_ADDR)  pi_rd = ev_r2a;
        else if (pi_address == AEN_ADDR)  pi_rd = aen;
`ifdef CMEM_PI_IRQ_MASK_EN
        else if (pi_address == MSK_ADDR)  pi_rd = pi_mask;
`endif
    end

    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            ev_a2r         <= '0;
            ev_r2a         <= '0;
            aen            <= AEN_RESET;
            cp_in_cmem_out <= '0;
            pi_rdata       <= '0;
            pi_ack         <= 1'b0;
            int_to_pi      <= 1'b0;
            int_to_amiga   <= 1'b0;
            state          <= IDLE;
`ifdef CMEM_PI_IRQ_MASK_EN
            pi_mask        <= 4'hF;
`endif
        end else begin
            int_to_pi    <= irq_pi_next;
            int_to_amiga <= |(ev_r2a & aen);

            // Clock port is serviced unconditionally; write beats a simultaneous read.
            if (cp_write_cmem) begin
                if (cp_address <= LAST_PLAIN)    mem[cp_address] <= cp_data_out;
                else if (cp_address == A2R_ADDR) ev_a2r <= ev_a2r | cp_data_out;
                else if (cp_address == R2A_ADDR) ev_r2a <= ev_r2a & ~cp_data_out;
                else if (cp_address == AEN_ADDR) aen <= cp_data_out;
            end else if (cp_read_cmem) begin
                cp_in_cmem_out <= cp_rd;
            end

            // Pi access only runs in a cycle with no cp strobe, so the two never collide.
            case (state)
                IDLE: begin
                    if (pi_req != pi_ack) state <= PI_ACCESS;
                end
                PI_ACCESS: begin
                    if (!cp_strobe) begin
                        if (pi_write) begin
                            if (pi_address <= LAST_PLAIN)    mem[pi_address] <= pi_wdata;
                            else if (pi_address == A2R_ADDR) ev_a2r <= ev_a2r & ~pi_wdata;
                            else if (pi_address == R2A_ADDR) ev_r2a <= ev_r2a | pi_wdata;
`ifdef CMEM_PI_IRQ_MASK_EN
                            else if (pi_address == MSK_ADDR) pi_mask <= pi_wdata;
`endif
                        end else begin
                            pi_rdata <= pi_rd;
                        end
                        pi_ack <= ~pi_ack;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed bench for cmem_arbiter: cp/Pi access, collision defer, event registers, reset.
// Define CMEM_PI_IRQ_MASK_EN for both files to exercise the Pi irq mask.
module tb_cmem_arbiter;

    localparam logic [3:0] AEN_RESET = 4'h0;

    logic       clk200 = 1'b0;
    logic       reset_n = 1'b0;
    logic       cp_read_cmem = 1'b0;
    logic       cp_write_cmem = 1'b0;
    logic [3:0] cp_address = '0;
    logic [3:0] cp_data_out = '0;
    logic [3:0] cp_in_cmem_out;
    logic       pi_req = 1'b0;
    logic       pi_ack;
    logic       pi_write = 1'b0;
    logic [3:0] pi_address = '0;
    logic [3:0] pi_wdata = '0;
    logic [3:0] pi_rdata;
    logic       int_to_pi;
    logic       int_to_amiga;

    int tests_run = 0;
    int failures = 0;

    cmem_arbiter #(
        .A2R_ADDR(4'hC), .R2A_ADDR(4'hE), .AEN_ADDR(4'hF), .AEN_RESET(AEN_RESET)
    ) dut (
        .clk200(clk200), .reset_n(reset_n),
        .cp_read_cmem(cp_read_cmem), .cp_write_cmem(cp_write_cmem),
        .cp_address(cp_address), .cp_data_out(cp_data_out), .cp_in_cmem_out(cp_in_cmem_out),
        .pi_req(pi_req), .pi_ack(pi_ack), .pi_write(pi_write), .pi_address(pi_address),
        .pi_wdata(pi_wdata), .pi_rdata(pi_rdata),
        .int_to_pi(int_to_pi), .int_to_amiga(int_to_amiga)
    );

    always #5 clk200 = ~clk200;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One-cycle clock-port strobe; returns 1ns after the edge that services it.
    task automatic cp_op(input logic wr, input logic rd, input logic [3:0] a, input logic [3:0] d);
        @(posedge clk200); #1;
        cp_write_cmem = wr; cp_read_cmem = rd; cp_address = a; cp_data_out = d;
        @(posedge clk200); #1;
        cp_write_cmem = 1'b0; cp_read_cmem = 1'b0;
    endtask

    // Toggle pi_req and wait for the matching ack; lat counts edges until it arrives.
    task automatic pi_op(input logic wr, input logic [3:0] a, input logic [3:0] d, output int lat);
        @(posedge clk200); #1;
        pi_write = wr; pi_address = a; pi_wdata = d; pi_req = ~pi_req;
        lat = 0;
        while (pi_ack !== pi_req && lat < 20) begin
            @(posedge clk200); #1;
            lat++;
        end
        if (pi_ack !== pi_req) begin
            tests_run++; failures++;
            $display("FAIL pi_ack_timeout addr=%h ack=%b req=%b", a, pi_ack, pi_req);
        end
    endtask

    task automatic test_reset;
        int lat;
        reset_n = 1'b0;
        #22;
        tests_run++;
        if ({cp_in_cmem_out, pi_rdata, pi_ack, int_to_pi, int_to_amiga} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {cp_in_cmem_out, pi_rdata, pi_ack, int_to_pi, int_to_amiga});
        end
        reset_n = 1'b1;
        cp_op(1'b0, 1'b1, 4'h3, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h0) begin
            failures++; $display("FAIL reset_cp_read got=%h want=0", cp_in_cmem_out);
        end
        pi_op(1'b0, 4'hF, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== AEN_RESET) begin
            failures++; $display("FAIL reset_pi_aen got=%h want=%h", pi_rdata, AEN_RESET);
        end
        tests_run++;
        if (lat != 2) begin
            failures++; $display("FAIL pi_latency got=%0d want=2", lat);
        end
    endtask

    task automatic test_basic_access;
        int lat;
        cp_op(1'b1, 1'b0, 4'h5, 4'hA);
        pi_op(1'b0, 4'h5, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== 4'hA) begin
            failures++; $display("FAIL pi_read_5 got=%h want=a", pi_rdata);
        end
        pi_op(1'b1, 4'h7, 4'h3, lat);
        cp_op(1'b0, 1'b1, 4'h7, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h3) begin
            failures++; $display("FAIL cp_read_7 got=%h want=3", cp_in_cmem_out);
        end
    endtask

    task automatic test_collision;
        // Pi write 0x2=6 pending; cp write 0x2=9 lands in the PI_ACCESS cycle.
        @(posedge clk200); #1;
        pi_write = 1'b1; pi_address = 4'h2; pi_wdata = 4'h6; pi_req = ~pi_req;
        @(posedge clk200); #1;
        cp_write_cmem = 1'b1; cp_address = 4'h2; cp_data_out = 4'h9;
        @(posedge clk200); #1;
        cp_write_cmem = 1'b0;
        tests_run++;
        if (pi_ack === pi_req) begin
            failures++; $display("FAIL collision_defer ack=%b want=%b", pi_ack, ~pi_req);
        end
        @(posedge clk200); #1;
        tests_run++;
        if (pi_ack !== pi_req) begin
            failures++; $display("FAIL collision_ack ack=%b want=%b", pi_ack, pi_req);
        end
        tests_run++;
        if (cp_in_cmem_out !== 4'h3) begin
            failures++; $display("FAIL collision_cp_out got=%h want=3", cp_in_cmem_out);
        end
        cp_op(1'b0, 1'b1, 4'h2, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h6) begin
            failures++; $display("FAIL collision_final got=%h want=6", cp_in_cmem_out);
        end
    endtask

    task automatic test_both_strobes;
        cp_op(1'b1, 1'b1, 4'h5, 4'hC);
        tests_run++;
        if (cp_in_cmem_out !== 4'h6) begin
            failures++; $display("FAIL both_strobe_hold got=%h want=6", cp_in_cmem_out);
        end
        cp_op(1'b0, 1'b1, 4'h5, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'hC) begin
            failures++; $display("FAIL both_strobe_write got=%h want=c", cp_in_cmem_out);
        end
    endtask

    task automatic test_a2r_event;
        int lat;
        cp_op(1'b1, 1'b0, 4'hC, 4'b0101);
        tests_run++;
        if (int_to_pi !== 1'b0) begin
            failures++; $display("FAIL int_pi_lag got=%b want=0", int_to_pi);
        end
        @(posedge clk200); #1;
        tests_run++;
        if (int_to_pi !== 1'b1) begin
            failures++; $display("FAIL int_pi_set got=%b want=1", int_to_pi);
        end
        pi_op(1'b1, 4'hC, 4'b0001, lat);
        cp_op(1'b0, 1'b1, 4'hC, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'b0100 || int_to_pi !== 1'b1) begin
            failures++;
            $display("FAIL a2r_w1c got=%b int=%b want=0100 int=1", cp_in_cmem_out, int_to_pi);
        end
        pi_op(1'b1, 4'hC, 4'b0100, lat);
        @(posedge clk200); #1;
        tests_run++;
        if (int_to_pi !== 1'b0) begin
            failures++; $display("FAIL int_pi_clear got=%b want=0", int_to_pi);
        end
    endtask

    task automatic test_r2a_event;
        int lat;
        cp_op(1'b1, 1'b0, 4'hF, 4'h2);
        pi_op(1'b1, 4'hE, 4'h3, lat);
        @(posedge clk200); #1;
        tests_run++;
        if (int_to_amiga !== 1'b1) begin
            failures++; $display("FAIL int_amiga_set got=%b want=1", int_to_amiga);
        end
        pi_op(1'b0, 4'hF, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== 4'h2) begin
            failures++; $display("FAIL pi_read_aen got=%h want=2", pi_rdata);
        end
        cp_op(1'b1, 1'b0, 4'hE, 4'h2);
        @(posedge clk200); #1;
        tests_run++;
        if (int_to_amiga !== 1'b0) begin
            failures++; $display("FAIL int_amiga_clear got=%b want=0", int_to_amiga);
        end
        cp_op(1'b0, 1'b1, 4'hE, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h1) begin
            failures++; $display("FAIL r2a_w1c got=%h want=1", cp_in_cmem_out);
        end
        pi_op(1'b1, 4'hF, 4'hF, lat);
        cp_op(1'b0, 1'b1, 4'hF, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h2) begin
            failures++; $display("FAIL pi_aen_write_ignored got=%h want=2", cp_in_cmem_out);
        end
    endtask

    task automatic test_addr_d;
        int lat;
        cp_op(1'b1, 1'b0, 4'hD, 4'hF);
        cp_op(1'b0, 1'b1, 4'hD, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h0) begin
            failures++; $display("FAIL cp_read_d got=%h want=0", cp_in_cmem_out);
        end
`ifdef CMEM_PI_IRQ_MASK_EN
        pi_op(1'b0, 4'hD, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== 4'hF) begin
            failures++; $display("FAIL mask_reset got=%h want=f", pi_rdata);
        end
        pi_op(1'b1, 4'hD, 4'h0, lat);
        cp_op(1'b1, 1'b0, 4'hC, 4'h1);
        @(posedge clk200); #1;
        @(posedge clk200); #1;
        tests_run++;
        if (int_to_pi !== 1'b0) begin
            failures++; $display("FAIL mask_int_pi got=%b want=0", int_to_pi);
        end
        pi_op(1'b0, 4'hD, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== 4'h0) begin
            failures++; $display("FAIL mask_readback got=%h want=0", pi_rdata);
        end
        cp_op(1'b0, 1'b1, 4'hD, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h0) begin
            failures++; $display("FAIL mask_cp_read got=%h want=0", cp_in_cmem_out);
        end
        pi_op(1'b1, 4'hC, 4'h1, lat);
`else
        pi_op(1'b0, 4'hD, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== 4'h0) begin
            failures++; $display("FAIL pi_read_d got=%h want=0", pi_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid_request;
        int lat;
        cp_op(1'b1, 1'b0, 4'hF, 4'h3);
        pi_op(1'b0, 4'h5, 4'h0, lat);
        cp_op(1'b0, 1'b1, 4'h5, 4'h0);
        @(posedge clk200); #1;
        tests_run++;
        if (int_to_amiga !== 1'b1 || pi_rdata !== 4'hC) begin
            failures++;
            $display("FAIL pre_reset int_amiga=%b pi_rdata=%h want 1 c", int_to_amiga, pi_rdata);
        end
        @(posedge clk200); #1;
        pi_write = 1'b1; pi_address = 4'h7; pi_wdata = 4'hF; pi_req = ~pi_req;
        @(posedge clk200); #1;
        reset_n = 1'b0; pi_req = 1'b0;
        #2;
        tests_run++;
        if ({cp_in_cmem_out, pi_rdata, pi_ack, int_to_pi, int_to_amiga} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h want=0",
                     {cp_in_cmem_out, pi_rdata, pi_ack, int_to_pi, int_to_amiga});
        end
        #10;
        reset_n = 1'b1;
        cp_op(1'b0, 1'b1, 4'h7, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== 4'h0) begin
            failures++; $display("FAIL mid_reset_mem7 got=%h want=0", cp_in_cmem_out);
        end
        cp_op(1'b0, 1'b1, 4'hF, 4'h0);
        tests_run++;
        if (cp_in_cmem_out !== AEN_RESET) begin
            failures++; $display("FAIL mid_reset_aen got=%h want=%h", cp_in_cmem_out, AEN_RESET);
        end
        pi_op(1'b0, 4'hE, 4'h0, lat);
        tests_run++;
        if (pi_rdata !== 4'h0 || lat != 2) begin
            failures++; $display("FAIL mid_reset_r2a got=%h lat=%0d want=0 lat=2", pi_rdata, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic_access();
        test_collision();
        test_both_strobes();
        test_a2r_event();
        test_r2a_event();
        test_addr_d();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
